// File: rtl/ps2_ascii_rx_if.sv
// PS/2 keyboard receiver bus: raw PS/2 lines in, decoded ASCII stream out.
interface ps2_ascii_rx_if;
  logic       ps2k_clk;
  logic       ps2k_data;
  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       shift_state;
  logic       frame_err;

  // Receiver side: samples the PS/2 lines, produces characters.
  modport slave (
    input  ps2k_clk, ps2k_data,
    output ascii_data, ascii_valid, shift_state, frame_err
  );

  // Keyboard/host side: drives the PS/2 lines, consumes characters.
  modport master (
    output ps2k_clk, ps2k_data,
    input  ascii_data, ascii_valid, shift_state, frame_err
  );
endinterface

// File: rtl/ps2_ascii_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 clock, frames
// 11-bit set-2 scan codes, and translates make codes of letters, digits,
// space and enter into ASCII. Receive-only; the PS/2 lines are never driven.
module ps2_ascii_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic          clk,
  input logic          rst_n,
  ps2_ascii_rx_if.slave bus
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  state_t        state, state_nxt;
  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic [TW-1:0] tmo_cnt;
  logic          timeout;
  logic          frame_ok;
  logic [7:0]    code;

  logic          brk, ext, shift_q;
  logic [7:0]    ascii_q;
  logic          valid_q, err_q;
  logic [9:0]    lut;

  // Two-flop synchronizers; idle level of both lines is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= bus.ps2k_clk;
      clk_s2  <= clk_s1;
      data_s1 <= bus.ps2k_data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter: the filtered clock follows only after FILT_LEN agreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_MAX) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Strobe is the cycle in which the filtered clock is about to fall.
  assign strobe = filt_clk & ~clk_s2 & (filt_cnt == FILT_MAX);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame next-state: start bit opens, ten strobes fill, CHECK lasts one cycle.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE:  if (strobe && !data_s2) state_nxt = SHIFT;
      SHIFT: begin
        if (strobe) begin
          if (bit_cnt == 4'd9) state_nxt = CHECK;
        end else if (tmo_cnt == TMO_MAX) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: shift in LSB first, count bits, time the gap between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sr      <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        SHIFT: begin
          if (strobe) begin
            sr      <= {data_s2, sr[9:1]};
            bit_cnt <= bit_cnt + 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

  // After ten shifts: sr[7:0] data, sr[8] parity, sr[9] stop.
  assign code     = sr[7:0];
  assign frame_ok = (^sr[8:0]) & sr[9];

  // Set-2 make code to {hit, is_letter, lowercase ASCII}.
  function automatic logic [9:0] lookup(input logic [7:0] c);
    case (c)
      8'h1C: lookup = {2'b11, 8'h61};
      8'h32: lookup = {2'b11, 8'h62};
      8'h21: lookup = {2'b11, 8'h63};
      8'h23: lookup = {2'b11, 8'h64};
      8'h24: lookup = {2'b11, 8'h65};
      8'h2B: lookup = {2'b11, 8'h66};
      8'h34: lookup = {2'b11, 8'h67};
      8'h33: lookup = {2'b11, 8'h68};
      8'h43: lookup = {2'b11, 8'h69};
      8'h3B: lookup = {2'b11, 8'h6A};
      8'h42: lookup = {2'b11, 8'h6B};
      8'h4B: lookup = {2'b11, 8'h6C};
      8'h3A: lookup = {2'b11, 8'h6D};
      8'h31: lookup = {2'b11, 8'h6E};
      8'h44: lookup = {2'b11, 8'h6F};
      8'h4D: lookup = {2'b11, 8'h70};
      8'h15: lookup = {2'b11, 8'h71};
      8'h2D: lookup = {2'b11, 8'h72};
      8'h1B: lookup = {2'b11, 8'h73};
      8'h2C: lookup = {2'b11, 8'h74};
      8'h3C: lookup = {2'b11, 8'h75};
      8'h2A: lookup = {2'b11, 8'h76};
      8'h1D: lookup = {2'b11, 8'h77};
      8'h22: lookup = {2'b11, 8'h78};
      8'h35: lookup = {2'b11, 8'h79};
      8'h1A: lookup = {2'b11, 8'h7A};
      8'h45: lookup = {2'b10, 8'h30};
      8'h16: lookup = {2'b10, 8'h31};
      8'h1E: lookup = {2'b10, 8'h32};
      8'h26: lookup = {2'b10, 8'h33};
      8'h25: lookup = {2'b10, 8'h34};
      8'h2E: lookup = {2'b10, 8'h35};
      8'h36: lookup = {2'b10, 8'h36};
      8'h3D: lookup = {2'b10, 8'h37};
      8'h3E: lookup = {2'b10, 8'h38};
      8'h46: lookup = {2'b10, 8'h39};
      8'h29: lookup = {2'b10, 8'h20};
      8'h5A: lookup = {2'b10, 8'h0D};
      default: lookup = 10'h000;
    endcase
  endfunction

  assign lut = lookup(code);

  // Scan-code decoder: prefix flags, shift tracking, ASCII pulse and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      brk     <= 1'b0;
      ext     <= 1'b0;
      shift_q <= 1'b0;
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= timeout | ((state == CHECK) & ~frame_ok);
      if (state == CHECK && frame_ok) begin
        if (code == 8'hE0) begin
          ext <= 1'b1;
        end else if (code == 8'hF0) begin
          brk <= 1'b1;
        end else if (brk) begin
          if (code == 8'h12 || code == 8'h59) shift_q <= 1'b0;
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          if (code == 8'h12 || code == 8'h59) begin
            shift_q <= 1'b1;
          end else if (!ext && lut[9]) begin
            ascii_q <= (lut[8] && shift_q) ? lut[7:0] - 8'h20 : lut[7:0];
            valid_q <= 1'b1;
          end
          ext <= 1'b0;
        end
      end
    end
  end

  assign bus.ascii_data  = ascii_q;
  assign bus.ascii_valid = valid_q;
  assign bus.shift_state = shift_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_ascii_rx.sv
// Bench for ps2_ascii_rx: bit-bangs PS/2 frames, queues the expected ASCII
// bytes, and checks each ascii_valid pulse, its latency, and error pulses.
module tb_ps2_ascii_rx;
  localparam int FILT_LEN = 8;
  localparam int TMO      = 2000;
  localparam int HALF     = 20;
  localparam int LAT      = FILT_LEN + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  ps2_ascii_rx_if bus();

  ps2_ascii_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int nchk = 0, nerr = 0;
  int cyc = 0, stop_cyc = 0;
  int err_cnt = 0, exp_err = 0;
  int npulse = 0, exp_pulse = 0;
  logic [7:0] exp_q[$];

  localparam logic [7:0] LETTERS[26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS[10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.ascii_valid === 1'b1) begin
      npulse++;
      if (exp_q.size() > 0) begin
        chk("ascii", {24'h0, bus.ascii_data}, {24'h0, exp_q.pop_front()});
        chk("latency", cyc - stop_cyc, LAT);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit is_stop);
    bus.ps2k_data = b;
    wait_cyc(HALF);
    bus.ps2k_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    wait_cyc(HALF);
    bus.ps2k_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input bit badpar);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i], 1'b0);
    send_bit((~^c) ^ badpar, 1'b0);
    send_bit(1'b1, 1'b1);
    bus.ps2k_data = 1'b1;
    wait_cyc(40);
  endtask

  task automatic key(input logic [7:0] c);
    send_frame(c, 1'b0);
  endtask

  task automatic key_exp(input logic [7:0] c, input logic [7:0] a);
    exp_q.push_back(a);
    exp_pulse++;
    send_frame(c, 1'b0);
  endtask

  initial begin
    logic [7:0] c;
    bus.ps2k_clk  = 1'b1;
    bus.ps2k_data = 1'b1;
    rst_n = 1'b0;
    wait_cyc(5);
    chk("rst_ascii", {24'h0, bus.ascii_data}, 32'h0);
    chk("rst_valid", {31'h0, bus.ascii_valid}, 32'h0);
    chk("rst_shift", {31'h0, bus.shift_state}, 32'h0);
    chk("rst_err",   {31'h0, bus.frame_err}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Plain letter
    key_exp(8'h1C, 8'h61);
    chk("pulses_a", npulse, exp_pulse);

    // Shifted letter with full make/release sequence
    key(8'h12);
    chk("shift_on", {31'h0, bus.shift_state}, 32'h1);
    key_exp(8'h1C, 8'h41);
    key(8'hF0); key(8'h1C);
    key(8'hF0); key(8'h12);
    chk("shift_off", {31'h0, bus.shift_state}, 32'h0);
    chk("pulses_A", npulse, exp_pulse);

    // Bad parity
    exp_err++;
    send_frame(8'h1C, 1'b1);
    chk("par_err", err_cnt, exp_err);
    chk("par_hold", {24'h0, bus.ascii_data}, 32'h41);
    chk("pulses_par", npulse, exp_pulse);

    // Extended codes produce nothing
    key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
    key_exp(8'h16, 8'h31);
    chk("pulses_ext", npulse, exp_pulse);

    // Full lowercase table and digits
    for (int i = 0; i < 26; i++) begin
      c = 8'h61 + 8'(i);
      key_exp(LETTERS[i], c);
    end
    for (int i = 0; i < 10; i++) begin
      c = 8'h30 + 8'(i);
      key_exp(DIGITS[i], c);
    end
    key_exp(8'h29, 8'h20);
    key_exp(8'h5A, 8'h0D);

    // Right shift, shifted letters, digit unaffected, typematic repeats
    key(8'h59);
    chk("rshift_on", {31'h0, bus.shift_state}, 32'h1);
    key_exp(8'h1A, 8'h5A);
    key_exp(8'h15, 8'h51);
    key_exp(8'h45, 8'h30);
    key(8'hF0); key(8'h59);
    chk("rshift_off", {31'h0, bus.shift_state}, 32'h0);
    key_exp(8'h1C, 8'h61);
    key_exp(8'h1C, 8'h61);
    key_exp(8'h1C, 8'h61);

    // Unknown code and extended make of a letter code: no output
    key(8'h76);
    key(8'hE0); key(8'h1C);
    key(8'hE0); key(8'hF0); key(8'h1C);
    chk("pulses_tbl", npulse, exp_pulse);
    chk("err_tbl", err_cnt, exp_err);

    // Timeout mid-frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    bus.ps2k_data = 1'b1;
    wait_cyc(TMO + 50);
    exp_err++;
    chk("tmo_err", err_cnt, exp_err);
    key_exp(8'h1C, 8'h61);

    // Reset mid-frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    bus.ps2k_data = 1'b1;
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    chk("mrst_ascii", {24'h0, bus.ascii_data}, 32'h0);
    chk("mrst_valid", {31'h0, bus.ascii_valid}, 32'h0);
    chk("mrst_shift", {31'h0, bus.shift_state}, 32'h0);
    chk("mrst_err",   {31'h0, bus.frame_err}, 32'h0);
    wait_cyc(40);
    key_exp(8'h29, 8'h20);

    chk("final_pulses", npulse, exp_pulse);
    chk("final_err", err_cnt, exp_err);
    chk("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/ps2_ascii_rx.md
PS2_ASCII_RX -- requirements
Module: ps2_ascii_rx

Interface
REQ-001 Parameter FILT_LEN, 8, consecutive equal synchronized samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT_CYC, 50000, clk cycles without a sample strobe inside a frame before the frame is aborted (1 ms at 50 MHz).
REQ-003 clk  input  1  system clock, 50 MHz; the block SHALL use this single clock only.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 ps2k_clk  input  1  PS/2 device clock, asynchronous, open-collector idle high.
REQ-006 ps2k_data  input  1  PS/2 device data, asynchronous.
REQ-007 ascii_data  output  8  last decoded ASCII byte, held until the next ascii_valid.
REQ-008 ascii_valid  output  1  one-cycle pulse, ascii_data new on the same cycle; drives the UART transmitter rx_int.
REQ-009 shift_state  output  1  high while either Shift key (12h/59h) is held.
REQ-010 frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 ps2k_clk and ps2k_data SHALL each pass a 2-FF synchronizer before any use.
REQ-012 Filtered PS/2 clock SHALL change only after FILT_LEN consecutive identical synchronized samples; its 1->0 transition SHALL produce a one-cycle sample strobe that samples synchronized data.
REQ-013 Frame FSM states: IDLE, SHIFT, CHECK; IDLE->SHIFT on a strobe with data=0 (start bit); a strobe with data=1 in IDLE SHALL be ignored.
REQ-014 SHIFT SHALL capture 8 data bits LSB first, then the parity bit, then the stop bit (10 strobes after the start bit), then go to CHECK.
REQ-015 CHECK, one cycle: frame valid iff XOR of 8 data bits and parity is 1 (odd) and stop bit is 1; otherwise pulse frame_err and discard; always return to IDLE.
REQ-016 While in SHIFT, a TIMEOUT_CYC-cycle gap between strobes SHALL pulse frame_err, discard the partial frame and return to IDLE; the counter SHALL clear on every strobe.
REQ-017 Decoder flags brk and ext: code E0h SHALL set ext; code F0h SHALL set brk; neither produces output.
REQ-018 Any other code with brk=1 is a release: 12h/59h clears shift_state; no output; brk and ext then clear.
REQ-019 Any other code with brk=0 is a make: 12h/59h sets shift_state; otherwise, if ext=0 and the code is in the table, output ASCII; ext then clears.
REQ-020 Table letters: 1C A,32 B,21 C,23 D,24 E,2B F,34 G,33 H,43 I,3B J,42 K,4B L,3A M,31 N,44 O,4D P,15 Q,2D R,1B S,2C T,3C U,2A V,1D W,22 X,35 Y,1A Z.
REQ-021 Letters SHALL map to 41h-5Ah when shift_state=1 and to 61h-7Ah otherwise.
REQ-022 Digits (unaffected by shift) SHALL map as 45->30h, 16->31h, 1E->32h, 26->33h, 25->34h, 2E->35h, 36->36h, 3D->37h, 3E->38h, 46->39h; 29->20h (space) and 5A->0Dh (enter) SHALL also map.
REQ-023 Codes not in the table, and all ext=1 make codes, SHALL produce no output and no error.
REQ-024 ascii_valid SHALL assert exactly 2 clk cycles after the cycle carrying the stop-bit strobe (CHECK at +1, pulse at +2).
REQ-025 Repeated make codes (typematic) SHALL each produce a pulse; a shift make/release SHALL update shift_state in the same cycle a letter pulse would occur.
REQ-026 The block is receive-only and SHALL never drive ps2k_clk or ps2k_data.

Reset
REQ-027 While rst_n=0 at a clk edge: FSM to IDLE, bit, filter and timeout counters to 0, brk=ext=0, ascii_data=00h, ascii_valid=0, shift_state=0, frame_err=0; the filtered clock SHALL reset high.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse; the first complete frame after release SHALL decode normally.

Verification
REQ-029 Frame 1Ch, odd parity correct, shift released -> one ascii_valid pulse, ascii_data=61h, 2 cycles after the stop-bit strobe.
REQ-030 Sequence 12,1C,F0,1C,F0,12 -> single pulse ascii_data=41h; shift_state 1 after the first frame, 0 after the last.
REQ-031 Frame 1Ch with parity bit inverted -> one frame_err pulse, no ascii_valid, ascii_data unchanged.
REQ-032 E0,75,E0,F0,75 then 16 -> exactly one pulse, ascii_data=31h; the extended codes produce nothing.
REQ-033 Start bit plus 5 data bits, then idle for TIMEOUT_CYC+10 cycles -> one frame_err pulse; a following 1Ch frame -> 61h.
REQ-034 rst_n low for 2 cycles after bit 4 of a frame -> all outputs 0, no frame_err; the next 29h frame -> ascii_data=20h.
